// File: rtl/apb_ram_arb_if.sv
// Bundle of the two requester ports and the shared APB bus around apb_ram_arb.
// The master modport is the arbiter's view: requests come in, APB and responses go out.
// The slave modport is the view of the environment: the requesters plus the APB slave.
interface apb_ram_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [1:0]        m_valid;
   logic [1:0]        m_ready;
   logic              m0_write;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m1_write;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic [1:0]        rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              perr;

   modport master (
      input  m_valid, m0_write, m0_addr, m0_wdata, m1_write, m1_addr, m1_wdata,
      input  prdata, pready, perr,
      output m_ready, rsp_valid, rsp_rdata, rsp_err,
      output paddr, psel, penable, pwrite, pwdata
   );

   modport slave (
      output m_valid, m0_write, m0_addr, m0_wdata, m1_write, m1_addr, m1_wdata,
      output prdata, pready, perr,
      input  m_ready, rsp_valid, rsp_rdata, rsp_err,
      input  paddr, psel, penable, pwrite, pwdata
   );
endinterface

// File: rtl/apb_ram_arb.sv
// Two-requester APB master sharing one APB slave.
// Round-robin grant in IDLE, then a SETUP/ACCESS APB transfer with an optional
// wait-state timeout; each completion returns a one-cycle pulse to its requester.
module apb_ram_arb #(
   parameter int          ADDR_W  = 32,
   parameter int          DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input logic            clk,
   input logic            rst,
   apb_ram_arb_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              lastGrant_q, lastGrant_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              pwrite_q, pwrite_d;
   logic [7:0]        waitCnt_q, waitCnt_d;
   logic [1:0]        rspValid_q, rspValid_d;
   logic [DATA_W-1:0] rspRdata_q, rspRdata_d;
   logic              rspErr_q, rspErr_d;
   logic              pick;
   logic [1:0]        readyRaw;

   // Registered state: reset drops any in-flight transfer and lets req0 win the
   // first contested arbitration by pretending req1 was granted last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         owner_q     <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         waitCnt_q   <= 8'd0;
         rspValid_q  <= 2'b00;
         rspRdata_q  <= '0;
         rspErr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         owner_q     <= owner_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         waitCnt_q   <= waitCnt_d;
         rspValid_q  <= rspValid_d;
         rspRdata_q  <= rspRdata_d;
         rspErr_q    <= rspErr_d;
      end
   end

   // Next-state logic: arbitrate and latch the request in IDLE, one SETUP cycle,
   // then hold ACCESS until pready or until the wait counter hits its limit.
   // The response pulse is only raised on the cycle right after completion.
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      owner_d     = owner_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      waitCnt_d   = waitCnt_q;
      rspValid_d  = 2'b00;
      rspRdata_d  = rspRdata_q;
      rspErr_d    = rspErr_q;
      pick        = 1'b0;
      readyRaw    = 2'b00;

      case (state_q)
         IDLE: begin
            if (bus.m_valid != 2'b00) begin
               if (bus.m_valid == 2'b11) begin
                  pick = ~lastGrant_q;
               end else begin
                  pick = bus.m_valid[1];
               end
               readyRaw    = pick ? 2'b10 : 2'b01;
               owner_d     = pick;
               lastGrant_d = pick;
               paddr_d     = pick ? bus.m1_addr  : bus.m0_addr;
               pwdata_d    = pick ? bus.m1_wdata : bus.m0_wdata;
               pwrite_d    = pick ? bus.m1_write : bus.m0_write;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            waitCnt_d = 8'd0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (bus.pready) begin
               rspErr_d   = bus.perr;
               rspRdata_d = (!pwrite_q && !bus.perr) ? bus.prdata : '0;
               rspValid_d = owner_q ? 2'b10 : 2'b01;
               state_d    = IDLE;
            end else if ((TIMEOUT != 0) && (waitCnt_q == TO_LAST)) begin
               rspErr_d   = 1'b1;
               rspRdata_d = '0;
               rspValid_d = owner_q ? 2'b10 : 2'b01;
               state_d    = IDLE;
            end else begin
               waitCnt_d = waitCnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output drive: APB strobes decode straight from state so reset clears them
   // immediately, and the accept strobe is forced low while reset is held.
   always_comb begin
      bus.m_ready   = rst ? 2'b00 : readyRaw;
      bus.psel      = (state_q == SETUP) || (state_q == ACCESS);
      bus.penable   = (state_q == ACCESS);
      bus.paddr     = paddr_q;
      bus.pwdata    = pwdata_q;
      bus.pwrite    = pwrite_q;
      bus.rsp_valid = rspValid_q;
      bus.rsp_rdata = rspRdata_q;
      bus.rsp_err   = rspErr_q;
   end

endmodule

// File: tb/tb_apb_ram_arb.sv
// Directed bench for apb_ram_arb with a small word-addressed RAM acting as the
// APB slave; the slave can be told to stall (pready low) or to signal perr.
module tb_apb_ram_arb;

   logic        clk;
   logic        rst;
   logic        stallMode;
   logic        perrMode;
   logic [31:0] mem [0:15];
   int          checks;
   int          passed;

   apb_ram_arb_if #(.ADDR_W(32), .DATA_W(32)) busIf ();

   apb_ram_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign busIf.pready = !stallMode;
   assign busIf.perr   = perrMode;
   assign busIf.prdata = perrMode ? 32'h0000_1234 : mem[busIf.paddr[5:2]];

   // RAM slave write port: commits on the completing ACCESS edge only.
   always @(posedge clk) begin
      if (busIf.psel && busIf.penable && busIf.pready && busIf.pwrite && !busIf.perr)
         mem[busIf.paddr[5:2]] <= busIf.pwdata;
   end

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic issue(input int req, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      if (req == 0) begin
         busIf.m0_write = wr;
         busIf.m0_addr  = addr;
         busIf.m0_wdata = wd;
         busIf.m_valid  = 2'b01;
      end else begin
         busIf.m1_write = wr;
         busIf.m1_addr  = addr;
         busIf.m1_wdata = wd;
         busIf.m_valid  = 2'b10;
      end
      #1;
      for (int i = 0; i < 20 && !busIf.m_ready[req]; i++) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (!busIf.m_ready[req]) $display("[TB] FAIL issue_accept req%0d: m_ready=%b never set", req, busIf.m_ready);
      else passed++;
      @(posedge clk);
      #1;
      busIf.m_valid = 2'b00;
   endtask

   task automatic waitRsp(output logic [1:0] v);
      v = 2'b00;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busIf.rsp_valid !== 2'b00) break;
      end
      v = busIf.rsp_valid;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      busIf.m_valid = 2'b11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busIf.psel, busIf.penable, busIf.pwrite} !== 3'b000) $display("[TB] FAIL reset_strobes: got %b want 000", {busIf.psel, busIf.penable, busIf.pwrite});
      else passed++;
      checks++;
      if ({busIf.paddr, busIf.pwdata} !== 64'd0) $display("[TB] FAIL reset_addr_data: paddr=%h pwdata=%h want 0", busIf.paddr, busIf.pwdata);
      else passed++;
      checks++;
      if ({busIf.rsp_valid, busIf.rsp_err, busIf.rsp_rdata} !== 35'd0) $display("[TB] FAIL reset_rsp: valid=%b err=%b rdata=%h want 0", busIf.rsp_valid, busIf.rsp_err, busIf.rsp_rdata);
      else passed++;
      checks++;
      if (busIf.m_ready !== 2'b00) $display("[TB] FAIL reset_ready: got %b want 00", busIf.m_ready);
      else passed++;
      busIf.m_valid = 2'b00;
      rst = 1'b0;
   endtask

   task automatic test_single_write;
      @(negedge clk);
      busIf.m0_write = 1'b1;
      busIf.m0_addr  = 32'h10;
      busIf.m0_wdata = 32'hDEAD_BEEF;
      busIf.m_valid  = 2'b01;
      #1;
      checks++;
      if (busIf.m_ready !== 2'b01) $display("[TB] FAIL wr_ready_c0: got %b want 01", busIf.m_ready);
      else passed++;
      @(negedge clk);
      busIf.m_valid = 2'b00;
      checks++;
      if ({busIf.psel, busIf.penable} !== 2'b10) $display("[TB] FAIL wr_setup_c1: psel,penable=%b want 10", {busIf.psel, busIf.penable});
      else passed++;
      checks++;
      if ({busIf.paddr, busIf.pwdata, busIf.pwrite} !== {32'h10, 32'hDEAD_BEEF, 1'b1}) $display("[TB] FAIL wr_bus_c1: paddr=%h pwdata=%h pwrite=%b", busIf.paddr, busIf.pwdata, busIf.pwrite);
      else passed++;
      @(negedge clk);
      checks++;
      if ({busIf.psel, busIf.penable} !== 2'b11) $display("[TB] FAIL wr_access_c2: psel,penable=%b want 11", {busIf.psel, busIf.penable});
      else passed++;
      @(negedge clk);
      checks++;
      if ({busIf.rsp_valid, busIf.rsp_err, busIf.psel} !== 4'b0100) $display("[TB] FAIL wr_rsp_c3: valid=%b err=%b psel=%b want 01,0,0", busIf.rsp_valid, busIf.rsp_err, busIf.psel);
      else passed++;
      checks++;
      if (mem[4] !== 32'hDEAD_BEEF) $display("[TB] FAIL wr_ram_word4: got %h want deadbeef", mem[4]);
      else passed++;
   endtask

   task automatic test_read_back;
      @(negedge clk);
      busIf.m1_write = 1'b0;
      busIf.m1_addr  = 32'h10;
      busIf.m1_wdata = 32'h0;
      busIf.m_valid  = 2'b10;
      #1;
      checks++;
      if (busIf.m_ready !== 2'b10) $display("[TB] FAIL rd_ready_c0: got %b want 10", busIf.m_ready);
      else passed++;
      @(negedge clk);
      busIf.m_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busIf.rsp_valid, busIf.rsp_err, busIf.rsp_rdata} !== {2'b10, 1'b0, 32'hDEAD_BEEF}) $display("[TB] FAIL rd_rsp_c3: valid=%b err=%b rdata=%h want 10,0,deadbeef", busIf.rsp_valid, busIf.rsp_err, busIf.rsp_rdata);
      else passed++;
   endtask

   task automatic test_round_robin;
      logic [1:0] expRdy;
      logic [1:0] expRsp;
      logic [1:0] expStb;
      @(negedge clk);
      busIf.m0_write = 1'b1;
      busIf.m0_addr  = 32'h20;
      busIf.m0_wdata = 32'h0000_00A0;
      busIf.m1_write = 1'b1;
      busIf.m1_addr  = 32'h24;
      busIf.m1_wdata = 32'h0000_00B1;
      busIf.m_valid  = 2'b11;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         expStb = (k % 3 == 0) ? 2'b00 : ((k % 3 == 1) ? 2'b10 : 2'b11);
         expRsp = (k % 3 != 0 || k == 0) ? 2'b00 : (((k / 3) % 2 == 1) ? 2'b01 : 2'b10);
         expRdy = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
         checks++;
         if ({busIf.psel, busIf.penable} !== expStb) $display("[TB] FAIL rr_strobes k=%0d: got %b want %b", k, {busIf.psel, busIf.penable}, expStb);
         else passed++;
         checks++;
         if (busIf.rsp_valid !== expRsp) $display("[TB] FAIL rr_rsp k=%0d: got %b want %b", k, busIf.rsp_valid, expRsp);
         else passed++;
         #1;
         checks++;
         if (busIf.m_ready !== expRdy) $display("[TB] FAIL rr_grant k=%0d: got %b want %b", k, busIf.m_ready, expRdy);
         else passed++;
      end
      @(negedge clk);
      busIf.m_valid = 2'b00;
      checks++;
      if (busIf.rsp_valid !== 2'b10) $display("[TB] FAIL rr_last_rsp: got %b want 10", busIf.rsp_valid);
      else passed++;
      checks++;
      if ({mem[8], mem[9]} !== {32'h0000_00A0, 32'h0000_00B1}) $display("[TB] FAIL rr_ram: word8=%h word9=%h want a0,b1", mem[8], mem[9]);
      else passed++;
   endtask

   task automatic test_timeout;
      logic expEn;
      stallMode = 1'b1;
      @(negedge clk);
      busIf.m0_write = 1'b0;
      busIf.m0_addr  = 32'h10;
      busIf.m_valid  = 2'b01;
      #1;
      checks++;
      if (busIf.m_ready !== 2'b01) $display("[TB] FAIL to_ready: got %b want 01", busIf.m_ready);
      else passed++;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) busIf.m_valid = 2'b00;
         expEn = (c >= 2) && (c <= 5);
         checks++;
         if (busIf.penable !== expEn) $display("[TB] FAIL to_penable c%0d: got %b want %b", c, busIf.penable, expEn);
         else passed++;
      end
      checks++;
      if ({busIf.rsp_valid, busIf.rsp_err, busIf.rsp_rdata, busIf.psel} !== {2'b01, 1'b1, 32'h0, 1'b0}) $display("[TB] FAIL to_rsp: valid=%b err=%b rdata=%h psel=%b want 01,1,0,0", busIf.rsp_valid, busIf.rsp_err, busIf.rsp_rdata, busIf.psel);
      else passed++;
      stallMode = 1'b0;
   endtask

   task automatic test_perr;
      logic [1:0] v;
      issue(1, 1'b0, 32'h10, 32'h0);
      waitRsp(v);
      checks++;
      if ({v, busIf.rsp_err, busIf.rsp_rdata} !== {2'b10, 1'b0, 32'hDEAD_BEEF}) $display("[TB] FAIL perr_pre_read: valid=%b err=%b rdata=%h want 10,0,deadbeef", v, busIf.rsp_err, busIf.rsp_rdata);
      else passed++;
      perrMode = 1'b1;
      issue(1, 1'b0, 32'h10, 32'h0);
      waitRsp(v);
      checks++;
      if ({v, busIf.rsp_err, busIf.rsp_rdata} !== {2'b10, 1'b1, 32'h0}) $display("[TB] FAIL perr_read: valid=%b err=%b rdata=%h want 10,1,0", v, busIf.rsp_err, busIf.rsp_rdata);
      else passed++;
      perrMode = 1'b0;
   endtask

   task automatic test_reset_in_access;
      logic [1:0] expRsp;
      stallMode = 1'b1;
      issue(1, 1'b1, 32'h30, 32'h55);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busIf.penable !== 1'b1) $display("[TB] FAIL rst_pre_access: penable=%b want 1", busIf.penable);
      else passed++;
      #1;
      rst = 1'b1;
      busIf.m0_write = 1'b1;
      busIf.m0_addr  = 32'h34;
      busIf.m0_wdata = 32'h66;
      busIf.m1_write = 1'b1;
      busIf.m1_addr  = 32'h38;
      busIf.m1_wdata = 32'h77;
      busIf.m_valid  = 2'b11;
      #1;
      checks++;
      if ({busIf.psel, busIf.penable, busIf.m_ready, busIf.rsp_valid} !== 6'b0) $display("[TB] FAIL rst_async: psel=%b penable=%b ready=%b rsp=%b want 0", busIf.psel, busIf.penable, busIf.m_ready, busIf.rsp_valid);
      else passed++;
      @(negedge clk);
      checks++;
      if (busIf.rsp_valid !== 2'b00) $display("[TB] FAIL rst_no_rsp: got %b want 00", busIf.rsp_valid);
      else passed++;
      rst = 1'b0;
      stallMode = 1'b0;
      #1;
      checks++;
      if (busIf.m_ready !== 2'b01) $display("[TB] FAIL rst_first_grant: got %b want 01", busIf.m_ready);
      else passed++;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 1) busIf.m_valid = 2'b00;
         expRsp = (c == 3) ? 2'b01 : 2'b00;
         checks++;
         if (busIf.rsp_valid !== expRsp) $display("[TB] FAIL rst_after_rsp c%0d: got %b want %b", c, busIf.rsp_valid, expRsp);
         else passed++;
      end
      checks++;
      if (mem[13] !== 32'h66) $display("[TB] FAIL rst_after_ram: word13=%h want 66", mem[13]);
      else passed++;
   endtask

   // Test sequence: each scenario leaves the arbiter idle for the next one.
   initial begin
      checks         = 0;
      passed         = 0;
      rst            = 1'b1;
      stallMode      = 1'b0;
      perrMode       = 1'b0;
      busIf.m_valid  = 2'b00;
      busIf.m0_write = 1'b0;
      busIf.m0_addr  = 32'h0;
      busIf.m0_wdata = 32'h0;
      busIf.m1_write = 1'b0;
      busIf.m1_addr  = 32'h0;
      busIf.m1_wdata = 32'h0;
      test_reset();
      test_single_write();
      test_read_back();
      test_round_robin();
      test_timeout();
      test_perr();
      test_reset_in_access();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
